sim_uart_bridge: RTL
====================

SIM_UART_BRIDGE -- requirements
Module: sim_uart_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 8: character width.
REQ-002 SHALL have parameter TX_DEPTH, default 16: TX FIFO entries, power of two, at least 2.
REQ-003 SHALL have parameter RX_DEPTH, default 8: RX FIFO entries, power of two, at least 2.
REQ-004 SHALL have parameter TX_GAP, default 0: minimum idle cycles between consecutive io_uart_out_valid pulses.
REQ-005 SHALL have port clock, input, 1: the single clock.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have ports tx_valid (input, 1), tx_data (input, DATA_W), tx_ready (output, 1): SoC-side character push.
REQ-008 SHALL have ports rx_valid (output, 1), rx_data (output, DATA_W), rx_ready (input, 1): SoC-side character pop.
REQ-009 SHALL have port rx_poll_en, input, 1: enables host polling for input.
REQ-010 SHALL have ports io_uart_out_valid (output, 1) and io_uart_out_ch (output, DATA_W): host console output.
REQ-011 SHALL have ports io_uart_in_valid (output, 1) and io_uart_in_ch (input, DATA_W): host input request and same-cycle reply.
REQ-012 SHALL have ports io_perfInfo_clean (input, 1) and io_perfInfo_dump (input, 1): perf control.
REQ-013 SHALL have ports perf_tx_cnt, perf_rx_cnt, perf_stall_cnt (output, 32 each): perf snapshots.

Function
REQ-014 SHALL drive tx_ready = TX FIFO not full, independent of tx_valid and of a same-cycle pop; a push occurs on tx_valid && tx_ready.
REQ-015 SHALL implement the drain FSM as IDLE -> EMIT (FIFO non-empty) -> GAP (TX_GAP>0) or EMIT/IDLE (TX_GAP=0) -> IDLE or EMIT when the gap counter reaches 0.
REQ-016 SHALL register io_uart_out_valid high for exactly one cycle per character, with io_uart_out_ch equal to the FIFO head, popping it at that edge.
REQ-017 SHALL give latency: a character pushed at edge k into an empty FIFO in IDLE is presented after edge k+1; with TX_GAP=0 a full FIFO drains one character per cycle.
REQ-018 SHALL hold io_uart_out_ch at 0 whenever io_uart_out_valid is low.
REQ-019 SHALL drive io_uart_in_valid = rx_poll_en && RX FIFO not full, combinationally.
REQ-020 SHALL, when io_uart_in_valid is high, sample io_uart_in_ch in the same cycle and push it unless it is all-ones (no character), which is discarded.
REQ-021 SHALL present the RX FIFO head show-ahead: rx_valid = not empty, rx_data = head; a pop occurs on rx_valid && rx_ready.
REQ-022 SHALL permit a simultaneous RX push and pop; a push into an empty FIFO SHALL be visible on rx_valid the next cycle.
REQ-023 SHALL keep live counters: tx (+1 per emitted character), rx (+1 per accepted character), stall (+1 per cycle with tx_valid && !tx_ready); each saturates at 0xFFFFFFFF.
REQ-024 SHALL, on io_perfInfo_clean, zero the live counters at the next edge, with clean winning over same-cycle increments.
REQ-025 SHALL, on io_perfInfo_dump, copy the pre-edge live counter values into the perf_* outputs; with dump and clean in the same cycle, the snapshot captures the pre-clear values.
REQ-026 SHALL wrap FIFO pointers modulo depth and use an extra wrap bit to distinguish full from empty.

Reset
REQ-027 SHALL, on reset low, asynchronously clear FIFO pointers, the FSM (IDLE), the gap counter, live counters and perf outputs; FIFO contents are discarded.
REQ-028 SHALL drive outputs during reset as: tx_ready=1, rx_valid=0, rx_data=0, io_uart_out_valid=0, io_uart_out_ch=0, perf_*=0; io_uart_in_valid follows REQ-019 with an empty FIFO.
REQ-029 SHALL discard any in-flight character when reset is asserted mid-drain, with no partial emission after release.

Structure
REQ-030 SHALL place the default parameter values, the FSM state enum and the NO_CHAR (all-ones) constant in package sim_uart_pkg.
REQ-031 SHALL instantiate sub-module sync_fifo (parameters WIDTH, DEPTH; show-ahead; full/empty flags) twice, once for TX and once for RX.

Verification
REQ-032 SHALL cover: push 0x48,0x69 in back-to-back cycles, TX_GAP=0 -> out_valid on 2 consecutive cycles with ch 0x48 then 0x69, first at edge k+2.
REQ-033 SHALL cover: TX_GAP=3, push 3 characters -> out_valid pulses separated by exactly 3 idle cycles.
REQ-034 SHALL cover: push 20 characters with TX_DEPTH=16 and the drain stalled by TX_GAP=15 -> tx_ready low when full, stall count exact, all 20 characters emitted in order.
REQ-035 SHALL cover: rx_poll_en=1, host returns 0xFF,0x41,0xFF,0x42 with rx_ready=0 -> FIFO holds 0x41,0x42; after filling RX_DEPTH, io_uart_in_valid=0.
REQ-036 SHALL cover: dump and clean in the same cycle after 5 emitted characters -> perf_tx_cnt=5 and a later dump shows 0.
REQ-037 SHALL cover: assert reset while 4 TX characters are queued -> no out_valid after release and tx_ready=1.

Source files
------------

// File: rtl/sim_uart_pkg.sv
// Shared definitions for the simulation UART bridge: parameter defaults,
// drain FSM states, the "no character" marker and a saturating counter helper.
package sim_uart_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_TX_DEPTH = 16;
  localparam int DEF_RX_DEPTH = 8;
  localparam int DEF_TX_GAP   = 0;

  // Widest character the bridge supports; NO_CHAR is sliced down to DATA_W.
  localparam int              MAX_DATA_W = 64;
  localparam logic [MAX_DATA_W-1:0] NO_CHAR = '1;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } drain_state_e;

  // Increment by one when enabled, sticking at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
    return (en && (value != CNT_MAX)) ? value + 32'd1 : value;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers for full/empty detection.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  // Flags from the pointers; pushes into a full FIFO and pops from an empty one are ignored.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty    = (wr_ptr_q == rd_ptr_q);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  // Pointer registers, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values,
    // independent of statement order.
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array written on accepted pushes.
  always_ff @(posedge clock) begin
    // NOTE: the array has no reset; cleared pointers make stale contents unreachable,
    // and leaving it unreset lets it map onto plain RAM.
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign head = mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/sim_uart_bridge.sv
// Bridges an SoC character stream to a simulator host console: TX characters
// are queued and emitted as single-cycle pulses, RX characters are polled from
// the host, and live/snapshot perf counters track traffic and back-pressure.
module sim_uart_bridge
  import sim_uart_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int TX_DEPTH = DEF_TX_DEPTH,
  parameter int RX_DEPTH = DEF_RX_DEPTH,
  parameter int TX_GAP   = DEF_TX_GAP
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  input  logic              rx_ready,
  input  logic              rx_poll_en,
  output logic              io_uart_out_valid,
  output logic [DATA_W-1:0] io_uart_out_ch,
  output logic              io_uart_in_valid,
  input  logic [DATA_W-1:0] io_uart_in_ch,
  input  logic              io_perfInfo_clean,
  input  logic              io_perfInfo_dump,
  output logic [31:0]       perf_tx_cnt,
  output logic [31:0]       perf_rx_cnt,
  output logic [31:0]       perf_stall_cnt
);

  logic              tx_full, tx_empty, tx_push, tx_pop;
  logic [DATA_W-1:0] tx_head;
  logic              rx_full, rx_empty, rx_push, rx_pop;
  logic [DATA_W-1:0] rx_head;

  drain_state_e      state_q, state_d;
  logic [31:0]       gap_q, gap_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_ch_q, out_ch_d;
  logic              try_emit;

  logic [31:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d, stall_cnt_q, stall_cnt_d;
  logic [31:0] perf_tx_q, perf_tx_d, perf_rx_q, perf_rx_d, perf_stall_q, perf_stall_d;

  // tx_ready depends only on occupancy, never on a same-cycle pop.
  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && tx_ready;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (tx_push),
    .push_data (tx_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  // Host polling is offered only while there is room; all-ones replies mean "nothing typed".
  assign io_uart_in_valid = rx_poll_en && !rx_full;
  assign rx_push          = io_uart_in_valid && (io_uart_in_ch != NO_CHAR[DATA_W-1:0]);
  assign rx_valid         = !rx_empty;
  assign rx_data          = rx_empty ? '0 : rx_head;
  assign rx_pop           = rx_valid && rx_ready;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rx_push),
    .push_data (io_uart_in_ch),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  // Drain FSM next state: emit the FIFO head, then honour TX_GAP idle cycles.
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    out_valid_d = 1'b0;
    out_ch_d    = '0;
    tx_pop      = 1'b0;
    try_emit    = 1'b0;
    case (state_q)
      ST_IDLE: try_emit = 1'b1;
      ST_EMIT: begin
        if (TX_GAP == 0) begin
          try_emit = 1'b1;
        end else begin
          state_d = ST_GAP;
          gap_d   = 32'(TX_GAP - 1);
        end
      end
      ST_GAP: begin
        if (gap_q == 32'd0) try_emit = 1'b1;
        else                gap_d    = gap_q - 32'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (try_emit) begin
      if (!tx_empty) begin
        state_d     = ST_EMIT;
        out_valid_d = 1'b1;
        out_ch_d    = tx_head;
        tx_pop      = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Drain FSM registers, including the registered console outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      gap_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign io_uart_out_valid = out_valid_q;
  assign io_uart_out_ch    = out_ch_q;

  // Live counters (clean wins) and snapshots taken from pre-edge live values.
  always_comb begin
    tx_cnt_d     = io_perfInfo_clean ? 32'd0 : sat_inc(tx_cnt_q, tx_pop);
    rx_cnt_d     = io_perfInfo_clean ? 32'd0 : sat_inc(rx_cnt_q, rx_push);
    stall_cnt_d  = io_perfInfo_clean ? 32'd0 : sat_inc(stall_cnt_q, tx_valid && !tx_ready);
    perf_tx_d    = io_perfInfo_dump ? tx_cnt_q    : perf_tx_q;
    perf_rx_d    = io_perfInfo_dump ? rx_cnt_q    : perf_rx_q;
    perf_stall_d = io_perfInfo_dump ? stall_cnt_q : perf_stall_q;
  end

  // Counter and snapshot registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_cnt_q     <= '0;
      rx_cnt_q     <= '0;
      stall_cnt_q  <= '0;
      perf_tx_q    <= '0;
      perf_rx_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      tx_cnt_q     <= tx_cnt_d;
      rx_cnt_q     <= rx_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      perf_tx_q    <= perf_tx_d;
      perf_rx_q    <= perf_rx_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_tx_cnt    = perf_tx_q;
  assign perf_rx_cnt    = perf_rx_q;
  assign perf_stall_cnt = perf_stall_q;

endmodule
